// File: rtl/lbr_reader_pkg.sv
// Shared definitions for the LBR read-side master: request encodings,
// reader state encodings and the entry-to-word address mapping.
package lbr_reader_pkg;

  // LBR request codes driven on lbrReq.
  typedef enum logic [1:0] {
    LBR_IDLE     = 2'b00,
    LBR_READ     = 2'b10,
    LBR_READ_CLR = 2'b11
  } lbr_req_t;

  // Reader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ_F = 3'd1,
    ST_CAP_F = 3'd2,
    ST_REQ_T = 3'd3,
    ST_CAP_T = 3'd4,
    ST_EMIT  = 3'd5,
    ST_FIN   = 3'd6
  } rd_state_t;

  // Entry i keeps its from-PC at word 2*i and its target at word 2*i+1.
  function automatic int unsigned lbr_from_addr(input int unsigned idx);
    return idx << 1;
  endfunction

  function automatic int unsigned lbr_to_addr(input int unsigned idx);
    return (idx << 1) | 32'd1;
  endfunction

endpackage

// File: rtl/lbr_reader_if.sv
// Bus bundle between the reader, the LBR read port and the record sink.
// Record stream: a record transfers on a rising edge where rec_valid and
// rec_ready are both high; once rec_valid rises, rec_index/rec_from/rec_to
// stay stable and rec_valid stays high until that transfer happens.
// LBR port: one lbrReq != 00 cycle per word; output_data is valid in the
// cycle after the request was sampled.
interface lbr_reader_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDRESS_BITS = 12,
  parameter int IDX_W        = 3
);
  logic [1:0]              lbrReq;
  logic [ADDRESS_BITS-1:0] RW_address;
  logic [DATA_WIDTH-1:0]   output_data;
  logic                    rec_valid;
  logic                    rec_ready;
  logic [IDX_W-1:0]        rec_index;
  logic [DATA_WIDTH-1:0]   rec_from;
  logic [DATA_WIDTH-1:0]   rec_to;

  modport master (
    output lbrReq, RW_address, rec_valid, rec_index, rec_from, rec_to,
    input  output_data, rec_ready
  );

  modport slave (
    input  lbrReq, RW_address, rec_valid, rec_index, rec_from, rec_to,
    output output_data, rec_ready
  );
endinterface

// File: rtl/lbr_reader.sv
// LBR reader: on start, reads every LBR entry (from-PC word, then target
// word), and emits one {index, from, to} record per entry on a valid/ready
// stream. Optionally turns the very last read into a read-and-clear and
// optionally drops all-zero entries. All outputs are registered.
module lbr_reader
  import lbr_reader_pkg::*;
#(
  parameter int   DATA_WIDTH   = 16,
  parameter int   ADDRESS_BITS = 12,
  parameter int   LBR_DEPTH    = 8,
  localparam int  IDX_W        = $clog2(LBR_DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              clear_on_done,
  input  logic              skip_empty,
  output logic              busy,
  output logic              done,
  output logic [IDX_W:0]    rec_count,
  output rd_state_t         o_dbg_state,
  lbr_reader_if.master      bus
);

  rd_state_t               r_state;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_clr;
  logic                    r_skip;
  logic [DATA_WIDTH-1:0]   r_from;
  logic [DATA_WIDTH-1:0]   r_to;
  logic                    r_valid;
  logic [IDX_W:0]          r_count;
  lbr_req_t                r_req;
  logic [ADDRESS_BITS-1:0] r_addr;
  logic                    r_busy;
  logic                    r_done;

  rd_state_t               w_next_state;
  logic [IDX_W-1:0]        w_next_idx;
  lbr_req_t                w_next_req;
  logic [ADDRESS_BITS-1:0] w_next_addr;
  logic                    w_last;
  logic                    w_cap_empty;
  logic                    w_entry_done;

  // Next state, entry index and the request/address the next state drives.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_next_req   = LBR_IDLE;
    w_next_addr  = r_addr;
    w_entry_done = 1'b0;
    w_last       = (r_idx == IDX_W'(LBR_DEPTH - 1));
    // In CAP_T the target word is on output_data right now.
    w_cap_empty  = (r_from == '0) && (bus.output_data == '0);

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_REQ_F;
          w_next_idx   = '0;
        end
      end
      ST_REQ_F: w_next_state = ST_CAP_F;
      ST_CAP_F: w_next_state = ST_REQ_T;
      ST_REQ_T: w_next_state = ST_CAP_T;
      ST_CAP_T: begin
        if (r_skip && w_cap_empty) w_entry_done = 1'b1;
        else                       w_next_state = ST_EMIT;
      end
      ST_EMIT: begin
        if (bus.rec_ready) w_entry_done = 1'b1;
      end
      ST_FIN:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase

    // Move on to the next entry, or finish after the last one.
    if (w_entry_done) begin
      if (w_last) begin
        w_next_state = ST_FIN;
      end else begin
        w_next_state = ST_REQ_F;
        w_next_idx   = r_idx + 1'b1;
      end
    end

    // Requests are registered, so they are decoded from the next state.
    if (w_next_state == ST_REQ_F) begin
      w_next_req  = LBR_READ;
      w_next_addr = ADDRESS_BITS'(lbr_from_addr(32'(w_next_idx)));
    end else if (w_next_state == ST_REQ_T) begin
      w_next_req  = (w_last && r_clr) ? LBR_READ_CLR : LBR_READ;
      w_next_addr = ADDRESS_BITS'(lbr_to_addr(32'(w_next_idx)));
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_clr   <= 1'b0;
      r_skip  <= 1'b0;
      r_from  <= '0;
      r_to    <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
      r_req   <= LBR_IDLE;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      r_req   <= w_next_req;
      r_addr  <= w_next_addr;
      r_busy  <= (w_next_state != ST_IDLE);
      r_done  <= (r_state == ST_FIN);
      r_valid <= (w_next_state == ST_EMIT);
      if (r_state == ST_IDLE && start) begin
        r_clr   <= clear_on_done;
        r_skip  <= skip_empty;
        r_count <= '0;
      end
      if (r_state == ST_CAP_F) r_from <= bus.output_data;
      if (r_state == ST_CAP_T) r_to   <= bus.output_data;
      if (r_state == ST_EMIT && bus.rec_ready) r_count <= r_count + 1'b1;
    end
  end

  assign bus.lbrReq     = r_req;
  assign bus.RW_address = r_addr;
  assign bus.rec_valid  = r_valid;
  assign bus.rec_index  = r_idx;
  assign bus.rec_from   = r_from;
  assign bus.rec_to     = r_to;
  assign busy           = r_busy;
  assign done           = r_done;
  assign rec_count      = r_count;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_lbr_reader.sv
// Bench for lbr_reader: an LBR memory model answers reads, a scoreboard
// holds expected records and expected read requests, and a negedge monitor
// drives rec_ready and checks everything the DUT presents.
module tb_lbr_reader;
  import lbr_reader_pkg::*;

  localparam int DW    = 16;
  localparam int AB    = 12;
  localparam int DEPTH = 8;
  localparam int IW    = 3;
  localparam int REC_W = IW + 2 * DW;
  localparam int WORDS = 2 * DEPTH;
  localparam int REQ_W = 2 + AB;

  logic          clock;
  logic          reset;
  logic          start;
  logic          clear_on_done;
  logic          skip_empty;
  logic          busy;
  logic          done;
  logic [IW:0]   rec_count;
  rd_state_t     dbg_state;

  lbr_reader_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .IDX_W(IW)) bus ();

  lbr_reader #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .LBR_DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .clear_on_done (clear_on_done),
    .skip_empty    (skip_empty),
    .busy          (busy),
    .done          (done),
    .rec_count     (rec_count),
    .o_dbg_state   (dbg_state),
    .bus           (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  logic [REC_W-1:0] exp_q[$];
  logic [REQ_W-1:0] addr_q[$];
  int total = 0;
  int bad   = 0;
  int req_cnt = 0;
  int clr_cnt = 0;
  int stall_idx  = -1;
  int stall_left = 0;
  bit rand_ready = 1'b0;
  logic             hold_pend = 1'b0;
  logic [REC_W-1:0] held;
  logic [DW-1:0]    mem[WORDS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- LBR memory model ----------------
  // Data for a sampled request appears the next cycle; noise otherwise.
  always @(posedge clock) begin
    if (bus.lbrReq[1]) begin
      bus.output_data <= mem[bus.RW_address[3:0]];
      if (bus.lbrReq == 2'b11)
        for (int k = 0; k < WORDS; k++) mem[k] = '0;
    end else begin
      bus.output_data <= DW'($urandom);
    end
  end

  // ---------------- sink driver + monitor ----------------
  always @(negedge clock) begin
    logic [REC_W-1:0] cur;
    logic [REQ_W-1:0] rq;
    // rec_ready for the coming edge
    if (stall_left > 0 && bus.rec_valid && int'(bus.rec_index) == stall_idx) begin
      bus.rec_ready = 1'b0;
      stall_left--;
    end else if (rand_ready) begin
      bus.rec_ready = ($urandom_range(0, 3) != 0);
    end else begin
      bus.rec_ready = 1'b1;
    end
    // a stalled record must be held unchanged
    if (hold_pend)
      check("rec_hold", {bus.rec_valid, bus.rec_index, bus.rec_from, bus.rec_to}, {1'b1, held});
    hold_pend = 1'b0;
    cur = {bus.rec_index, bus.rec_from, bus.rec_to};
    if (bus.rec_valid) begin
      if (bus.rec_ready) begin
        if (exp_q.size() == 0) check("rec_unexpected", cur, '0);
        else                   check("rec", cur, exp_q.pop_front());
      end else begin
        hold_pend = 1'b1;
        held      = cur;
      end
    end
    // LBR requests in order, with the right code
    if (bus.lbrReq != 2'b00) begin
      req_cnt++;
      if (bus.lbrReq == 2'b11) clr_cnt++;
      rq = {bus.lbrReq, bus.RW_address};
      if (addr_q.size() == 0) check("req_unexpected", rq, '0);
      else                    check("lbr_req", rq, addr_q.pop_front());
    end
  end

  // ---------------- reference model ----------------
  // Walks the LBR contents as the scan will see them; returns the record
  // count and the edge offset at which done is visible after start.
  task automatic push_scan(input bit clr, input bit skip, output int n_rec, output int cost);
    logic [DW-1:0] f, t;
    n_rec = 0;
    cost  = 1;
    for (int e = 0; e < DEPTH; e++) begin
      f = mem[2*e];
      t = mem[2*e+1];
      addr_q.push_back({2'b10, AB'(2*e)});
      addr_q.push_back({(clr && e == DEPTH-1) ? 2'b11 : 2'b10, AB'(2*e+1)});
      if (skip && f == 0 && t == 0) begin
        cost += 4;
      end else begin
        exp_q.push_back({IW'(e), f, t});
        n_rec++;
        cost += 5;
      end
    end
  endtask

  // ---------------- stimulus drivers ----------------
  task automatic fill_pattern(input int valid_n);
    for (int e = 0; e < DEPTH; e++) begin
      mem[2*e]   = (e < valid_n) ? DW'(e) : '0;
      mem[2*e+1] = (e < valid_n) ? DW'(1 << e) : '0;
    end
  endtask

  task automatic fill_random();
    for (int e = 0; e < DEPTH; e++) begin
      if ($urandom_range(0, 2) == 0) begin
        mem[2*e] = '0; mem[2*e+1] = '0;
      end else begin
        mem[2*e] = DW'($urandom); mem[2*e+1] = DW'($urandom);
      end
    end
  endtask

  task automatic run_scan(input bit clr, input bit skip, input int extra,
                          input bit check_time, input bit extra_start);
    int n_rec, cost, k, extra_done;
    @(negedge clock);
    check("idle_before_start", {busy, 3'(dbg_state)}, {1'b0, 3'(ST_IDLE)});
    push_scan(clr, skip, n_rec, cost);
    req_cnt = 0;
    clr_cnt = 0;
    start = 1'b1; clear_on_done = clr; skip_empty = skip;
    @(negedge clock);
    start = 1'b0; clear_on_done = 1'b0; skip_empty = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 3000) begin
      @(negedge clock);
      k++;
      start         = extra_start && (k == 10);
      clear_on_done = extra_start && (k == 10);
      skip_empty    = extra_start && (k == 10);
    end
    start = 1'b0; clear_on_done = 1'b0; skip_empty = 1'b0;
    if (k >= 3000) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done after %0d cycles", k);
    end
    if (check_time) check("done_time", k, cost + extra);
    check("rec_count", rec_count, n_rec);
    check("req_count", req_cnt, WORDS);
    check("clr_count", clr_cnt, clr);
    check("exp_q_left", exp_q.size(), 0);
    check("addr_q_left", addr_q.size(), 0);
    check("busy_at_done", busy, 0);
    @(negedge clock);
    check("done_pulse", done, 0);
    if (extra_start) begin
      extra_done = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clock);
        if (done || busy) extra_done++;
      end
      check("single_done", extra_done, 0);
    end
    exp_q.delete();
    addr_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int k, n_rec, cost;
    reset = 1'b0; start = 1'b0; clear_on_done = 1'b0; skip_empty = 1'b0;
    fill_pattern(DEPTH);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_req",   {bus.lbrReq, bus.RW_address}, '0);
    check("rst_rec",   {bus.rec_valid, bus.rec_index, bus.rec_from, bus.rec_to}, '0);
    check("rst_flags", {busy, done, rec_count}, '0);
    check("rst_state", 3'(dbg_state), 3'(ST_IDLE));
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // full pattern scan, then read-and-clear, then skip scan on cleared LBR
    run_scan(0, 0, 0, 1, 0);
    run_scan(1, 0, 0, 1, 0);
    check("lbr_cleared", {mem[0], mem[15]}, '0);
    run_scan(0, 1, 0, 1, 0);

    // only entries 0..2 populated
    fill_pattern(3);
    run_scan(0, 1, 0, 1, 0);
    run_scan(0, 0, 0, 1, 0);

    // backpressure on record 2
    fill_pattern(DEPTH);
    stall_idx = 2; stall_left = 5;
    run_scan(0, 0, 5, 1, 0);
    stall_idx = -1;

    // start while busy is ignored
    run_scan(0, 0, 0, 1, 1);

    // random contents, random sink readiness
    rand_ready = 1'b1;
    for (int it = 0; it < 6; it++) begin
      fill_random();
      run_scan(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0, 0, 0);
    end
    rand_ready = 1'b0;

    // reset during REQ_T of entry 4 with clear requested
    fill_pattern(DEPTH);
    @(negedge clock);
    push_scan(1, 0, n_rec, cost);
    clr_cnt = 0;
    start = 1'b1; clear_on_done = 1'b1;
    @(negedge clock);
    start = 1'b0; clear_on_done = 1'b0;
    for (k = 0; k < 22; k++) @(negedge clock);
    check("req_t_entry4", {bus.lbrReq, bus.RW_address}, {2'b10, AB'(9)});
    #2 reset = 1'b0;
    #1;
    check("midrst_req",   {bus.lbrReq, bus.RW_address}, '0);
    check("midrst_rec",   {bus.rec_valid, bus.rec_index, bus.rec_from, bus.rec_to}, '0);
    check("midrst_flags", {busy, done, rec_count}, '0);
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("midrst_no_clr", clr_cnt, 0);
    check("midrst_mem_kept", mem[15], 16'h0080);
    run_scan(0, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
